// File: rtl/write_aligner_if.sv
// write_aligner_if: store request and memory write channel bundle
interface write_aligner_if;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  mem_op;
  logic [31:0] addr;
  logic [31:0] datain;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_web;
  logic        done;
  logic        split;
  logic        op_err;
  modport master (
    output req_valid, mem_op, addr, datain, mem_ready,
    input  req_ready, mem_valid, mem_addr, mem_wdata, mem_web, done, split, op_err
  );
  modport slave (
    input  req_valid, mem_op, addr, datain, mem_ready,
    output req_ready, mem_valid, mem_addr, mem_wdata, mem_web, done, split, op_err
  );
endinterface

// File: rtl/write_aligner.sv
// write_aligner: splits unaligned byte/half/word stores into lane-shifted word writes
module write_aligner (
  input logic clk,
  input logic rst,
  write_aligner_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WR0, WR1} state_t;
  state_t      state;
  logic [1:0]  off;
  logic [3:0]  mask;
  logic [31:0] data;
  logic        two;
  logic [1:0]  in_sz;
  logic [1:0]  in_off;
  logic [3:0]  in_mask;
  logic        in_two;
  always_comb begin
    in_sz   = bus.mem_op[1:0];
    in_off  = bus.addr[1:0];
    in_mask = in_sz == 2'b00 ? 4'b0001 : in_sz == 2'b01 ? 4'b0011 : 4'b1111;
    in_two  = (in_sz == 2'b01 && in_off == 2'd3) || (in_sz == 2'b10 && in_off != 2'd0);
  end
  assign bus.req_ready = state == IDLE;
  // Memory-side outputs are loaded on state entry so they hold under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      off           <= 2'd0;
      mask          <= 4'd0;
      data          <= 32'd0;
      two           <= 1'b0;
      bus.mem_valid <= 1'b0;
      bus.mem_addr  <= 32'd0;
      bus.mem_wdata <= 32'd0;
      bus.mem_web   <= 4'd0;
      bus.done      <= 1'b0;
      bus.split     <= 1'b0;
      bus.op_err    <= 1'b0;
    end else begin
      bus.done   <= 1'b0;
      bus.split  <= 1'b0;
      bus.op_err <= 1'b0;
      case (state)
        IDLE: if (bus.req_valid) begin
          if (in_sz == 2'b11) begin
            bus.done   <= 1'b1;
            bus.op_err <= 1'b1;
          end else begin
            state         <= WR0;
            off           <= in_off;
            mask          <= in_mask;
            data          <= bus.datain;
            two           <= in_two;
            bus.mem_valid <= 1'b1;
            bus.mem_addr  <= {bus.addr[31:2], 2'b00};
            bus.mem_wdata <= bus.datain << {in_off, 3'b000};
            bus.mem_web   <= in_mask << in_off;
          end
        end
        WR0: if (bus.mem_ready) begin
          if (two) begin
            state         <= WR1;
            bus.mem_addr  <= bus.mem_addr + 32'd4;
            bus.mem_wdata <= data >> (6'd32 - {1'b0, off, 3'b000});
            bus.mem_web   <= mask >> (3'd4 - {1'b0, off});
          end else begin
            state         <= IDLE;
            bus.mem_valid <= 1'b0;
            bus.mem_addr  <= 32'd0;
            bus.mem_wdata <= 32'd0;
            bus.mem_web   <= 4'd0;
            bus.done      <= 1'b1;
          end
        end
        WR1: if (bus.mem_ready) begin
          state         <= IDLE;
          bus.mem_valid <= 1'b0;
          bus.mem_addr  <= 32'd0;
          bus.mem_wdata <= 32'd0;
          bus.mem_web   <= 4'd0;
          bus.done      <= 1'b1;
          bus.split     <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_write_aligner.sv
// tb_write_aligner: table-driven store vectors with access/completion scoreboards
module tb_write_aligner;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  write_aligner_if bus();
  write_aligner dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    logic [4:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    int          n;
    logic [31:0] a0;
    logic [31:0] w0;
    logic [3:0]  e0;
    logic [31:0] a1;
    logic [31:0] w1;
    logic [3:0]  e1;
    logic        sp;
    logic        err;
  } vec_t;
  typedef struct {
    logic [31:0] a;
    logic [31:0] w;
    logic [3:0]  e;
  } acc_t;
  typedef struct {
    logic sp;
    logic err;
  } fin_t;
  acc_t aq[$];
  fin_t fq[$];
  int vectors = 0;
  int miscompares = 0;
  vec_t t[12];
  task automatic check(input string n, input logic [71:0] act, input logic [71:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask
  task automatic fail(input string n);
    vectors++;
    miscompares++;
    $display("FAIL %s", n);
  endtask
  always @(negedge clk) begin
    acc_t x;
    fin_t f;
    if (!rst) begin
      if (bus.mem_valid && bus.mem_ready) begin
        if (aq.size() == 0) fail("unexpected access");
        else begin
          x = aq.pop_front();
          check("access", {4'h0, bus.mem_addr, bus.mem_wdata, bus.mem_web}, {4'h0, x.a, x.w, x.e});
        end
      end
      if (!bus.mem_valid) check("idle outputs", {4'h0, bus.mem_addr, bus.mem_wdata, bus.mem_web}, 72'h0);
      if (bus.done) begin
        if (fq.size() == 0) fail("unexpected done");
        else begin
          f = fq.pop_front();
          check("done flags", {70'h0, bus.split, bus.op_err}, {70'h0, f.sp, f.err});
        end
      end else check("stray pulse", {70'h0, bus.split, bus.op_err}, 72'h0);
    end
  end
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] d);
    bus.req_valid = 1'b1;
    bus.mem_op = op;
    bus.addr = a;
    bus.datain = d;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask
  task automatic wait_done();
    int i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (!bus.done && i < 50);
    if (!bus.done) fail("done timeout");
    else check("ready with done", {71'h0, bus.req_ready}, 72'h1);
  endtask
  initial begin
    bus.req_valid = 1'b0;
    bus.mem_op = 5'd0;
    bus.addr = 32'd0;
    bus.datain = 32'd0;
    bus.mem_ready = 1'b1;
    t[0]  = '{5'b00000, 32'h00001002, 32'h000000AB, 1, 32'h00001000, 32'h00AB0000, 4'b0100, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0};
    t[1]  = '{5'b00010, 32'h00002003, 32'h11223344, 2, 32'h00002000, 32'h44000000, 4'b1000, 32'h00002004, 32'h00112233, 4'b0111, 1'b1, 1'b0};
    t[2]  = '{5'b00001, 32'hFFFFFFFF, 32'h0000BEEF, 2, 32'hFFFFFFFC, 32'hEF000000, 4'b1000, 32'h00000000, 32'h000000BE, 4'b0001, 1'b1, 1'b0};
    t[3]  = '{5'b00011, 32'h00000040, 32'h12345678, 0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1};
    t[4]  = '{5'b00010, 32'h00000100, 32'hDEADBEEF, 1, 32'h00000100, 32'hDEADBEEF, 4'b1111, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0};
    t[5]  = '{5'b00001, 32'h00000201, 32'h00001234, 1, 32'h00000200, 32'h00123400, 4'b0110, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0};
    t[6]  = '{5'b00001, 32'h00000302, 32'h00005678, 1, 32'h00000300, 32'h56780000, 4'b1100, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0};
    t[7]  = '{5'b00010, 32'h00000401, 32'hA1B2C3D4, 2, 32'h00000400, 32'hB2C3D400, 4'b1110, 32'h00000404, 32'h000000A1, 4'b0001, 1'b1, 1'b0};
    t[8]  = '{5'b00010, 32'h00000502, 32'h01020304, 2, 32'h00000500, 32'h03040000, 4'b1100, 32'h00000504, 32'h00000102, 4'b0011, 1'b1, 1'b0};
    t[9]  = '{5'b00000, 32'h00000603, 32'h0000007F, 1, 32'h00000600, 32'h7F000000, 4'b1000, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0};
    t[10] = '{5'b11100, 32'h00000700, 32'h00000055, 1, 32'h00000700, 32'h00000055, 4'b0001, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0};
    t[11] = '{5'b00001, 32'h00000800, 32'h0000AAAA, 1, 32'h00000800, 32'h0000AAAA, 4'b0011, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0};
    #12;
    check("reset outputs", {bus.req_ready, bus.mem_valid, bus.done, bus.split, bus.op_err, bus.mem_web, bus.mem_addr, bus.mem_wdata},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0});
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (t[i].n > 0) aq.push_back('{t[i].a0, t[i].w0, t[i].e0});
      if (t[i].n > 1) aq.push_back('{t[i].a1, t[i].w1, t[i].e1});
      fq.push_back('{t[i].sp, t[i].err});
      issue(t[i].op, t[i].addr, t[i].data);
      wait_done();
    end
    bus.mem_ready = 1'b0;
    aq.push_back('{32'h00000010, 32'hCAFEF00D, 4'b1111});
    fq.push_back('{1'b0, 1'b0});
    issue(5'b00010, 32'h00000010, 32'hCAFEF00D);
    repeat (5) begin
      @(negedge clk);
      check("backpressure hold", {3'h0, bus.mem_valid, bus.mem_addr, bus.mem_wdata, bus.mem_web},
            {3'h0, 1'b1, 32'h00000010, 32'hCAFEF00D, 4'b1111});
    end
    @(posedge clk);
    #1 bus.mem_ready = 1'b1;
    wait_done();
    bus.mem_ready = 1'b0;
    aq.push_back('{32'h00002000, 32'h44000000, 4'b1000});
    issue(5'b00010, 32'h00002003, 32'h11223344);
    bus.mem_ready = 1'b1;
    @(posedge clk);
    #1 bus.mem_ready = 1'b0;
    check("in WR1", {3'h0, bus.mem_valid, bus.mem_addr, bus.mem_wdata, bus.mem_web},
          {3'h0, 1'b1, 32'h00002004, 32'h00112233, 4'b0111});
    #2 rst = 1'b1;
    #1 check("async reset", {bus.req_ready, bus.mem_valid, bus.done, bus.split, bus.op_err, bus.mem_web, bus.mem_addr, bus.mem_wdata},
             {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0});
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("ready after reset", {71'h0, bus.req_ready}, 72'h1);
    bus.mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    aq.push_back('{32'h00001000, 32'h00AB0000, 4'b0100});
    fq.push_back('{1'b0, 1'b0});
    issue(5'b00000, 32'h00001002, 32'h000000AB);
    wait_done();
    repeat (2) @(negedge clk);
    check("queues drained", 72'(aq.size() + fq.size()), 72'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/write_aligner.md
WRITE_ALIGNER -- requirements
Module: write_aligner

Interface
REQ-001 The block SHALL expose these ports, clock and reset first:
- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  store request from pipeline
- req_ready  out  1  block can accept a request
- mem_op  in  5  [1:0] size (00 byte, 01 half, 10 word, 11 reserved); [4:2] ignored for stores
- addr  in  32  byte address of store
- datain  in  32  store data, right-justified (byte in [7:0], half in [15:0])
- mem_valid  out  1  memory write request valid
- mem_ready  in  1  memory accepts write this cycle
- mem_addr  out  32  word-aligned memory address ([1:0] always 00)
- mem_wdata  out  32  lane-shifted write data
- mem_web  out  4  byte write enables, active-high, bit i = byte lane i
- done  out  1  one-cycle pulse, request fully written or rejected
- split  out  1  one-cycle pulse with done, request needed two accesses
- op_err  out  1  one-cycle pulse with done, reserved size code

Function
REQ-002 The block SHALL use states IDLE, WR0, WR1; req_ready SHALL equal (state==IDLE).
REQ-003 On req_valid && req_ready the block SHALL capture mem_op[1:0], addr, datain; off = addr[1:0]; mask = 0001/0011/1111 for byte/half/word.
REQ-004 With a legal size, the next state SHALL be WR0; with size 11 the state SHALL stay IDLE, no memory access, and done and op_err SHALL pulse the following cycle.
REQ-005 In WR0: mem_valid=1, mem_addr={addr[31:2],2'b00}, mem_wdata=datain<<(8*off) truncated to 32 bits, mem_web=(mask<<off)[3:0].
REQ-006 The request SHALL need a split iff (half && off==3) or (word && off!=0); byte never splits.
REQ-007 In WR0 on mem_ready: no split -> IDLE; split -> WR1.
REQ-008 In WR1: mem_valid=1, mem_addr={addr[31:2],2'b00}+4 modulo 2^32 (0xFFFFFFFC wraps to 0x00000000), mem_wdata=datain>>(8*(4-off)), mem_web=mask>>(4-off).
REQ-009 In WR1 on mem_ready the state SHALL return to IDLE.
REQ-010 done SHALL pulse exactly one cycle, registered, in the cycle after the final memory handshake; split SHALL pulse with it for two-access requests.
REQ-011 While mem_valid=1 and mem_ready=0, mem_addr, mem_wdata and mem_web SHALL hold stable; wait length is unbounded.
REQ-012 In IDLE mem_valid SHALL be 0, mem_web 0000, mem_wdata and mem_addr 0.
REQ-013 A new request SHALL be accepted in the same cycle done pulses (state is IDLE then); back-to-back throughput is one access per cycle with mem_ready held high, plus one IDLE cycle per request.
REQ-014 mem_web SHALL never be nonzero when mem_valid=0.

Reset
REQ-015 On rst=1, regardless of clock, state SHALL go to IDLE and mem_valid, done, split, op_err SHALL be 0, mem_web 0000, mem_addr and mem_wdata 0.
REQ-016 Reset asserted mid-request (WR0 or WR1) SHALL abandon the request with no done pulse; req_ready SHALL be 1 on the first cycle after rst deasserts.

Verification
REQ-017 Byte store: addr=0x00001002, datain=0x000000AB, mem_ready=1 -> one access, mem_addr=0x00001000, mem_wdata=0x00AB0000, mem_web=0100, done pulse, split=0.
REQ-018 Split word: addr=0x00002003, datain=0x11223344 -> access 1: addr 0x00002000, wdata 0x44000000, web 1000; access 2: addr 0x00002004, wdata 0x00112233, web 0111; done and split pulse.
REQ-019 Half at off 3 with wrap: addr=0xFFFFFFFF, datain=0x0000BEEF -> access 1: addr 0xFFFFFFFC, web 1000, wdata 0xEF000000; access 2: addr 0x00000000, web 0001, wdata 0x000000BE.
REQ-020 Backpressure: aligned word at 0x10, mem_ready low 5 cycles -> mem_valid/addr/wdata/web stable all 5 cycles, single done after handshake.
REQ-021 Reserved size: mem_op[1:0]=11 -> mem_valid never asserts, done and op_err pulse together next cycle.
REQ-022 Reset in WR1 of a split word store -> mem_valid drops immediately, no done, next request accepted normally.
